// File: rtl/lift_disp_pkg.sv
// Shared glyph codes and active-low segment patterns (a..g = [6:0]) for the lift panel display.
package lift_disp_pkg;

    typedef logic [3:0] glyph_t;

    localparam glyph_t DN_A  = 4'd0;
    localparam glyph_t DN_B  = 4'd1;
    localparam glyph_t UP_A  = 4'd2;
    localparam glyph_t UP_B  = 4'd3;
    localparam glyph_t FLR0  = 4'd4;
    localparam glyph_t FLR1  = 4'd5;
    localparam glyph_t FLR2  = 4'd6;
    localparam glyph_t FLR3  = 4'd7;
    localparam glyph_t FLR4  = 4'd8;
    localparam glyph_t ALARM = 4'd9;
    localparam glyph_t OFF   = 4'd10;

    localparam logic [6:0] SEG_DN_A  = 7'b1110011;
    localparam logic [6:0] SEG_DN_B  = 7'b1111100;
    localparam logic [6:0] SEG_UP_A  = 7'b1101110;
    localparam logic [6:0] SEG_UP_B  = 7'b0011111;
    localparam logic [6:0] SEG_FLR0  = 7'b0000001;
    localparam logic [6:0] SEG_FLR1  = 7'b1001111;
    localparam logic [6:0] SEG_FLR2  = 7'b0010010;
    localparam logic [6:0] SEG_FLR3  = 7'b0000110;
    localparam logic [6:0] SEG_FLR4  = 7'b1001100;
    localparam logic [6:0] SEG_ALARM = 7'b0110000;
    localparam logic [6:0] SEG_OFF   = 7'b1111111;

endpackage

// File: rtl/lift_glyph_rom.sv
// Combinational glyph code to active-low segment decode; unused codes render blank.
module lift_glyph_rom
    import lift_disp_pkg::*;
(
    input  glyph_t     code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (code_i)
            DN_A:    seg_o = SEG_DN_A;
            DN_B:    seg_o = SEG_DN_B;
            UP_A:    seg_o = SEG_UP_A;
            UP_B:    seg_o = SEG_UP_B;
            FLR0:    seg_o = SEG_FLR0;
            FLR1:    seg_o = SEG_FLR1;
            FLR2:    seg_o = SEG_FLR2;
            FLR3:    seg_o = SEG_FLR3;
            FLR4:    seg_o = SEG_FLR4;
            ALARM:   seg_o = SEG_ALARM;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/lift_disp_scan.sv
// Time-multiplexed seven-segment scanner with anti-ghost blanking and alarm blink.
// Define LIFT_DISP_DIM_EN to add the 3-bit bright input for per-slot anode dimming.
module lift_disp_scan
    import lift_disp_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int SLOT_CYC       = 25000,
    parameter int BLANK_CYC      = 2,
    parameter int BLINK_HALF_CYC = 25000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] code_in,
    input  logic                  load,
`ifdef LIFT_DISP_DIM_EN
    input  logic [2:0]            bright,
`endif
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   an
);

    localparam int SW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int BW = (BLINK_HALF_CYC > 1) ? $clog2(BLINK_HALF_CYC) : 1;

    localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT_CYC - 1);
    localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_CYC - 1);

    logic [SW-1:0]       slot_q, slot_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
    logic                hidden_q, hidden_d;
    glyph_t              shadow_q [N_DIGITS];
    glyph_t              shadow_d [N_DIGITS];
    glyph_t              code_q, code_d;
    logic [6:0]          seg_q, seg_d, rom_seg;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic                slot_start, blanking, anode_on;

    assign slot_start = (slot_q == '0);
    assign blanking   = (slot_q < BLANK_END);
    // The slot's glyph is taken from shadow only at slot start, so a load never tears a slot.
    assign code_d     = slot_start ? shadow_q[idx_q] : code_q;

    lift_glyph_rom u_rom (
        .code_i (code_d),
        .seg_o  (rom_seg)
    );

`ifdef LIFT_DISP_DIM_EN
    logic [2:0]  bright_q, bright_d;
    logic [31:0] post_off, sub_phase;

    // Post-blank time is scaled into 8 sub-phases; the anode is lit for sub-phases 0..bright.
    always_comb begin
        bright_d  = slot_start ? bright : bright_q;
        post_off  = 32'(slot_q) - 32'(BLANK_CYC);
        sub_phase = (post_off * 32'd8) / 32'(SLOT_CYC - BLANK_CYC);
        anode_on  = !blanking && (sub_phase <= 32'(bright_d));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bright_q <= 3'd7;
        else     bright_q <= bright_d;
    end
`else
    assign anode_on = !blanking;
`endif

    always_comb begin
        slot_d = slot_q + 1'b1;
        idx_d  = idx_q;
        if (slot_q == SLOT_LAST) begin
            slot_d = '0;
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        blink_cnt_d = blink_cnt_q + 1'b1;
        hidden_d    = hidden_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            hidden_d    = ~hidden_q;
        end

        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            shadow_d[k] = load ? code_in[4*k +: 4] : shadow_q[k];
        end

        seg_d = (hidden_q && (code_d == ALARM)) ? SEG_OFF : rom_seg;

        an_d = '1;
        if (anode_on) an_d[idx_q] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q      <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            hidden_q    <= 1'b0;
            code_q      <= OFF;
            seg_q       <= SEG_OFF;
            an_q        <= '1;
            for (int unsigned k = 0; k < N_DIGITS; k++) shadow_q[k] <= OFF;
        end else begin
            slot_q      <= slot_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            hidden_q    <= hidden_d;
            code_q      <= code_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            for (int unsigned k = 0; k < N_DIGITS; k++) shadow_q[k] <= shadow_d[k];
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_lift_disp_scan.sv
// Scoreboard bench: the driver queues expected {an, seg} per cycle; the monitor pops and compares.
module tb_lift_disp_scan;

    localparam int ND = 4;
    localparam int SC = 8;
    localparam int BC = 2;
    localparam int BH = 64;

    typedef struct packed {
        logic [3:0]  an;
        logic [6:0]  seg;
        logic [31:0] t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] code_in = '0;
    logic [6:0]  seg;
    logic [3:0]  an;
`ifdef LIFT_DISP_DIM_EN
    logic [2:0]  bright = 3'd7;
`endif

    exp_t        sb[$];
    int unsigned vecs = 0;
    int unsigned errs = 0;

    always #5 clk = ~clk;

    lift_disp_scan #(
        .N_DIGITS       (ND),
        .SLOT_CYC       (SC),
        .BLANK_CYC      (BC),
        .BLINK_HALF_CYC (BH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .code_in (code_in),
        .load    (load),
`ifdef LIFT_DISP_DIM_EN
        .bright  (bright),
`endif
        .seg     (seg),
        .an      (an)
    );

    function automatic logic [6:0] glyph(input logic [3:0] c);
        case (c)
            4'd0:    return 7'b1110011;
            4'd1:    return 7'b1111100;
            4'd2:    return 7'b1101110;
            4'd3:    return 7'b0011111;
            4'd4:    return 7'b0000001;
            4'd5:    return 7'b1001111;
            4'd6:    return 7'b0010010;
            4'd7:    return 7'b0000110;
            4'd8:    return 7'b1001100;
            4'd9:    return 7'b0110000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Monitor: registered outputs are sampled 2 time units after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vecs++;
                if (an !== e.an || seg !== e.seg) begin
                    errs++;
                    $display("FAIL scan t=%0d: an=%b seg=%b, expected an=%b seg=%b",
                             e.t, an, seg, e.an, e.seg);
                end
            end
        end
    end

    task automatic check_reset(input string name);
        vecs++;
        if (an !== 4'b1111 || seg !== 7'b1111111) begin
            errs++;
            $display("FAIL %s: an=%b seg=%b, expected an=1111 seg=1111111", name, an, seg);
        end
    endtask

    // Assert reset asynchronously, between clock edges, and check outputs clear at once.
    task automatic async_reset(input string name);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset(name);
        repeat (2) @(negedge clk);
    endtask

    // Releases reset, loads c0 on the first edge and c1 on the edge of cycle tl.
    task automatic run(input string name, input logic [15:0] c0, input int unsigned n,
                       input int unsigned tl, input logic [15:0] c1);
        logic [3:0]  sh [ND];
        logic [3:0]  lat;
        exp_t        e;
        int unsigned idx;
        for (int unsigned k = 0; k < ND; k++) sh[k] = 4'd10;
        lat = 4'd10;
        @(negedge clk);
        rst = 1'b0;
        for (int unsigned t = 0; t < n; t++) begin
            if (t != 0) @(negedge clk);
            idx = (t / SC) % ND;
            if (t % SC == 0) lat = sh[idx];
            e.an  = (t % SC < BC) ? 4'b1111 : ~(4'b0001 << idx);
            e.seg = (((t / BH) % 2 == 1) && lat == 4'd9) ? 7'b1111111 : glyph(lat);
            e.t   = t;
            sb.push_back(e);
            load    = (t == 0) || (t == tl);
            code_in = (t == tl) ? c1 : c0;
            if (load) for (int unsigned k = 0; k < ND; k++) sh[k] = code_in[4*k +: 4];
        end
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        vecs++;
        if (sb.size() != 0) begin
            errs++;
            $display("FAIL %s drain: %0d expectations left, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset("reset_initial");

        run("scan", 16'h4567, 40, 1000, 16'h0000);
        async_reset("reset_mid_slot");

        run("atomic_load", 16'h7777, 72, 36, 16'h7772);
        async_reset("reset_after_load");

        run("blink", 16'h4494, 200, 1000, 16'h0000);
        async_reset("reset_after_blink");

        run("undefined", 16'hFD80, 40, 1000, 16'h0000);
        async_reset("reset_after_undef");

        run("arrows", 16'h321A, 40, 1000, 16'h0000);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/lift_disp_scan.md
Name: lift_disp_scan

Overview:
- Parametrised, time-multiplexed seven-segment driver for the lift panel.
- Holds one 4-bit glyph code per digit and scans N_DIGITS common-anode digits round-robin, with anti-ghost blanking.
- Alarm glyphs blink autonomously.
- Sits between the lift controller (floor/direction/alarm codes) and the board's shared segment bus and per-digit anode lines.

Parameters:
- N_DIGITS, 4, number of multiplexed digits (1..8).
- SLOT_CYC, 25000, clock cycles each digit is addressed. At 100 MHz with 4 digits this gives a 1 kHz refresh.
- BLANK_CYC, 2, cycles at the start of each slot with all anodes off (anti-ghost); must be < SLOT_CYC.
- BLINK_HALF_CYC, 25000000, half-period of the alarm blink in clock cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- code_in  in  4*N_DIGITS  glyph codes; digit k = code_in[4k+3:4k]; digit 0 is rightmost.
- load  in  1  single-cycle strobe; captures code_in into the shadow register.
- seg  out  7  segments a..g = seg[6:0], active-low.
- an  out  N_DIGITS  digit anodes, active-low, at most one low at any time.

Behaviour:
- Glyph map (active-low seg):
  - Direction arrows: 0 = 1110011 (down-a), 1 = 1111100 (down-b), 2 = 1101110 (up-a), 3 = 0011111 (up-b).
  - Floors: 4 = 0000001 (floor 0), 5 = 1001111 (floor 1), 6 = 0010010 (floor 2), 7 = 0000110 (floor 3), 8 = 1001100 (floor 4).
  - Alarm: 9 = 0110000.
  - Off: 10 = 1111111; 11..15 = 1111111 (off, defined, no latch).
- Reset (async assert, sync release):
  - seg = 1111111, an = all 1.
  - Shadow = all code 10.
  - slot counter = 0, digit index = 0, blink counter = 0, blink phase = visible.
- Shadow register:
  - On a clk edge with load = 1, shadow <= code_in.
  - The new value is visible from the next slot boundary; the current slot never changes glyph mid-slot.
  - load held high reloads every cycle (legal).
- Scan:
  - slot counter runs 0..SLOT_CYC-1.
  - On wrap, digit index advances; index N_DIGITS-1 wraps to 0.
  - Per-slot glyph is latched from shadow at slot start.
- Outputs are registered, with 1-cycle latency from the counter state.
- an:
  - When slot counter < BLANK_CYC, an = all 1 (registered one cycle later).
  - Otherwise an[idx] = 0 and all other bits = 1.
  - seg is updated during blanking so it is stable before the anode enables.
- Blink:
  - Blink counter runs 0..BLINK_HALF_CYC-1; on wrap the phase toggles.
  - In the hidden phase, any slot whose latched code is 9 drives seg = 1111111. The anode still follows the normal scan.
  - Other codes are unaffected.
- N_DIGITS = 1: index is constant 0; blanking still applies each slot.
- Reset mid-slot: immediate return to the reset state; the first slot after release is digit 0, starting with blanking.

Optional Feature:
- Macro: LIFT_DISP_DIM_EN.
- With the macro defined:
  - Extra port bright (in, 3 bits).
  - The post-blank part of each slot is divided into 8 equal sub-phases by slot-counter scaling.
  - An anode is enabled only in sub-phases 0..bright; bright = 7 is full on, bright = 0 is 1/8 duty.
  - bright is sampled at slot start.
- Without the macro: no port; the anode is on for the whole post-blank slot.

Decomposition:
- Package lift_disp_pkg:
  - Glyph code constants (DN_A, DN_B, UP_A, UP_B, FLR0..FLR4, ALARM, OFF).
  - Segment pattern constants.
  - A glyph_t 4-bit typedef.
- Sub-module lift_glyph_rom: purely combinational code -> seg decode per the glyph map above, with default OFF.
- lift_disp_scan holds the counters, shadow, blink and output registers.

Test Plan:
All scenarios use N_DIGITS=4, SLOT_CYC=8, BLANK_CYC=2, BLINK_HALF_CYC=64.
- Reset: assert rst mid-slot -> seg=1111111 and an=1111 asynchronously; after release the first enabled anode is an=1110 at cycle 3 (after 2 blank cycles plus 1 latency).
- Scan: load codes {4,5,6,7} on digits 3..0 -> over 32 cycles an steps 1110, 1101, 1011, 0111 with seg 0000110, 0010010, 1001111, 0000001 respectively. No two anodes are ever low; an=1111 for 2 cycles per slot.
- Atomic load: pulse load with digit0 = 2 mid-way through digit 0's slot -> the current slot keeps the old glyph; the next digit-0 slot shows 1101110.
- Blink: digit 1 = 9, others = 4 -> digit 1 seg alternates 0110000 and 1111111 every 64 cycles; the other digits stay at 0000001 throughout.
- Undefined codes: digit 2 = 13 -> seg=1111111 during its slot while the anode still cycles normally.
- LIFT_DISP_DIM_EN with bright=1 -> anode low for 2/8 of the post-blank slot; bright=7 -> identical to the non-dim build.
